// File: rtl/store_buffer_pkg.sv
// Shared sizing defaults and the datamem port-grant encoding for the store buffer.
package store_buffer_pkg;

  localparam int unsigned SbDepth     = 4;
  localparam int unsigned SbAddrW     = 64;
  localparam int unsigned SbDataW     = 64;
  localparam int unsigned SbStarveLim = 8;

  // Owner of the single datamem port in a given cycle.
  typedef enum logic [1:0] {
    GntNone,
    GntLoad,
    GntDrain
  } port_gnt_e;

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side store/load/fence signals plus the datamem port, seen from the store buffer.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W = SbAddrW,
  parameter int unsigned DATA_W = SbDataW
) ();

  logic                  st_valid;
  logic [ADDR_W-1:0]     st_addr;
  logic [DATA_W-1:0]     st_data;
  logic                  st_ready;
  logic                  ld_valid;
  logic [ADDR_W-1:0]     ld_addr;
  logic [DATA_W-1:0]     ld_data;
  logic                  ld_stall;
  logic                  fence_req;
  logic                  fence_done;
  logic [ADDR_W-1:0]     mem_address;
  logic [2*DATA_W-1:0]   mem_write_data;
  logic                  mem_write_en;
  logic                  mem_read_en;
  logic                  mem_en;
  logic [DATA_W-1:0]     mem_read_data;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, fence_req, mem_read_data,
    input  st_ready, ld_data, ld_stall, fence_done,
    input  mem_address, mem_write_data, mem_write_en, mem_read_en, mem_en
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, fence_req, mem_read_data,
    output st_ready, ld_data, ld_stall, fence_done,
    output mem_address, mem_write_data, mem_write_en, mem_read_en, mem_en
  );

endinterface

// File: rtl/store_buffer_match.sv
// Load-address compare against all queued stores; youngest matching entry wins.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = SbDepth,
  parameter int unsigned ADDR_W = SbAddrW,
  localparam int unsigned PtrW  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [ADDR_W-1:0] addr_i [DEPTH],
  input  logic [PtrW-1:0]   head_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              hit_o,
  output logic [PtrW-1:0]   index_o
);

  logic [PtrW-1:0] idx;

  // Walk oldest to youngest so a later (younger) match overrides an earlier one.
  always_comb begin
    hit_o   = 1'b0;
    index_o = head_i;
    idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_i + PtrW'(i);
      if (valid_i[idx] && (addr_i[idx] == ld_addr_i)) begin
        hit_o   = 1'b1;
        index_o = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store queue in front of datamem: loads own the port, stores drain when it is free,
// with load forwarding, a starvation-forced drain and a fence drain point.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = SbDepth,
  parameter int unsigned ADDR_W     = SbAddrW,
  parameter int unsigned DATA_W     = SbDataW,
  parameter int unsigned STARVE_LIM = SbStarveLim
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave bus_io
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned StW  = (STARVE_LIM > 1) ? $clog2(STARVE_LIM) : 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [StW-1:0]    starve_q, starve_d;

  logic            match_hit, ld_hit, load_miss, force_drain, drain, enq;
  logic [PtrW-1:0] match_idx;
  port_gnt_e       gnt;

  store_buffer_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_match (
    .valid_i   (valid_q),
    .addr_i    (addr_q),
    .head_i    (head_q),
    .ld_addr_i (bus_io.ld_addr),
    .hit_o     (match_hit),
    .index_o   (match_idx)
  );

  assign ld_hit      = bus_io.ld_valid & match_hit;
  assign load_miss   = bus_io.ld_valid & ~match_hit;
  assign force_drain = (count_q != '0) && (starve_q == StW'(STARVE_LIM - 1));
  assign drain       = (count_q != '0) && (!load_miss || force_drain);
  assign enq         = bus_io.st_valid & bus_io.st_ready;

  always_comb begin
    valid_d  = valid_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    starve_d = '0;
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (enq) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    unique case ({enq, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if ((count_q != '0) && load_miss && !force_drain) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      if (enq) begin
        addr_q[tail_q] <= bus_io.st_addr;
        data_q[tail_q] <= bus_io.st_data;
      end
    end
  end

  always_comb begin
    if (load_miss && !force_drain) gnt = GntLoad;
    else if (drain)                gnt = GntDrain;
    else                           gnt = GntNone;
  end

  always_comb begin
    bus_io.st_ready       = (count_q != CntW'(DEPTH)) && !bus_io.fence_req;
    bus_io.fence_done     = (count_q == '0);
    bus_io.ld_stall       = load_miss & force_drain;
    bus_io.mem_read_en    = 1'b0;
    bus_io.mem_write_en   = 1'b0;
    bus_io.mem_address    = '0;
    bus_io.mem_write_data = '0;
    bus_io.ld_data        = '0;
    unique case (gnt)
      GntLoad: begin
        bus_io.mem_read_en = 1'b1;
        bus_io.mem_address = bus_io.ld_addr;
        bus_io.ld_data     = bus_io.mem_read_data;
      end
      GntDrain: begin
        bus_io.mem_write_en   = 1'b1;
        bus_io.mem_address    = addr_q[head_q];
        bus_io.mem_write_data = {{DATA_W{1'b0}}, data_q[head_q]};
      end
      default: ;
    endcase
    if (ld_hit) bus_io.ld_data = data_q[match_idx];
    bus_io.mem_en = bus_io.mem_write_en | bus_io.mem_read_en;
  end

endmodule
